// File: rtl/ternary_add_arb_pkg.sv
// Shared definitions for the three-operand adder sharing wrapper:
// a constant clog2 helper and the output-register state encoding.
package ternary_add_arb_pkg;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/ternary_add_arb_rr_arb.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr,
// wrapping modulo NREQ. Reusable by any resource-sharing wrapper.
module rr_arb
    import ternary_add_arb_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int IDW = (NREQ > 1) ? clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant_onehot,
    output logic [IDW-1:0]  grant_idx,
    output logic            any
);

    int idx;

    assign any = |req;

    // Walk offsets from farthest to nearest so the closest requester wins last.
    always_comb begin
        grant_idx = '0;
        idx       = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (req[idx[IDW-1:0]]) begin
                grant_idx = idx[IDW-1:0];
            end
        end
    end

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
        assign grant_onehot[gi] = any && (grant_idx == IDW'(gi));
    end

endmodule

// File: rtl/ternary_add_arb.sv
// One registered a+b+c adder shared by NREQ valid/ready requesters through a
// round-robin arbiter, with a one-entry tagged result register.
module ternary_add_arb
    import ternary_add_arb_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int NREQ     = 4,
    parameter bit SIGN_EXT = 1'b0,
    localparam int IDW     = (NREQ > 1) ? clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ*WIDTH-1:0] req_c,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [WIDTH+1:0]      res_sum,
    output logic [IDW-1:0]        res_id
);

    localparam int SW = WIDTH + 2;

    out_state_t       state_reg, state_next;
    logic [IDW-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [SW-1:0]    sum_reg, sum_next;
    logic [IDW-1:0]   id_reg;
    logic [IDW-1:0]   grant_idx;
    logic [NREQ-1:0]  grant_onehot;
    logic             any_req;
    logic             can_acc;
    logic             accept;
    logic [WIDTH-1:0] a_arr [NREQ];
    logic [WIDTH-1:0] b_arr [NREQ];
    logic [WIDTH-1:0] c_arr [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
        assign b_arr[gi] = req_b[gi*WIDTH +: WIDTH];
        assign c_arr[gi] = req_c[gi*WIDTH +: WIDTH];
    end

    rr_arb #(.NREQ(NREQ)) u_arb (
        .req          (req_valid),
        .ptr          (rr_ptr_reg),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx),
        .any          (any_req)
    );

    function automatic logic [SW-1:0] ext(input logic [WIDTH-1:0] x);
        return SIGN_EXT ? {{2{x[WIDTH-1]}}, x} : {2'b00, x};
    endfunction

    // Two guard bits make the three-way sum exact in both signed and unsigned modes.
    assign sum_next = ext(a_arr[grant_idx]) + ext(b_arr[grant_idx]) + ext(c_arr[grant_idx]);
    assign accept   = |(req_valid & req_ready);

    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (accept) begin
            rr_ptr_next = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            EMPTY:   if (accept) state_next = FULL;
            FULL:    if (res_ready && !accept) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    // Output logic; req_ready is forced low while reset is held
    always_comb begin
        res_valid = (state_reg == FULL);
        can_acc   = (state_reg == EMPTY) || res_ready;
        req_ready = (rst_n && can_acc && any_req) ? grant_onehot : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_reg    <= '0;
            id_reg     <= '0;
            rr_ptr_reg <= '0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
            if (accept) begin
                sum_reg <= sum_next;
                id_reg  <= grant_idx;
            end
        end
    end

    assign res_sum = sum_reg;
    assign res_id  = id_reg;

endmodule

// File: tb/tb_ternary_add_arb.sv
// Directed bench for ternary_add_arb: drivers push expected results into
// scoreboard queues, negedge monitors pop and compare on each handshake.
module tb_ternary_add_arb;

    typedef struct packed {
        logic [1:0] id;
        logic [9:0] sum;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [3:0]  req_valid, req_ready;
    logic [31:0] req_a, req_b, req_c;
    logic        res_valid, res_ready;
    logic [9:0]  res_sum;
    logic [1:0]  res_id;

    logic [3:0]  req_valid_s, req_ready_s;
    logic [31:0] req_a_s, req_b_s, req_c_s;
    logic        res_valid_s, res_ready_s;
    logic [9:0]  res_sum_s;
    logic [1:0]  res_id_s;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ternary_add_arb #(.WIDTH(8), .NREQ(4), .SIGN_EXT(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_sum(res_sum), .res_id(res_id)
    );

    ternary_add_arb #(.WIDTH(8), .NREQ(4), .SIGN_EXT(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_s), .req_ready(req_ready_s),
        .req_a(req_a_s), .req_b(req_b_s), .req_c(req_c_s),
        .res_valid(res_valid_s), .res_ready(res_ready_s),
        .res_sum(res_sum_s), .res_id(res_id_s)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        req_a[i*8 +: 8] = a;
        req_b[i*8 +: 8] = b;
        req_c[i*8 +: 8] = c;
    endtask

    task automatic push0(input logic [1:0] id, input logic [9:0] sum);
        exp_t e;
        e.id  = id;
        e.sum = sum;
        q0.push_back(e);
    endtask

    // Scoreboard monitors: one per DUT instance
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && res_valid && res_ready) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL unsigned_result: got id=%0d sum=%0h expected no result", res_id, res_sum);
            end else begin
                e = q0.pop_front();
                if (res_sum !== e.sum || res_id !== e.id) begin
                    errors++;
                    $display("FAIL unsigned_result: got id=%0d sum=%0h expected id=%0d sum=%0h",
                             res_id, res_sum, e.id, e.sum);
                end else begin
                    $display("result id=%0d sum=%0h ok", res_id, res_sum);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && res_valid_s && res_ready_s) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL signed_result: got id=%0d sum=%0h expected no result", res_id_s, res_sum_s);
            end else begin
                e = q1.pop_front();
                if (res_sum_s !== e.sum || res_id_s !== e.id) begin
                    errors++;
                    $display("FAIL signed_result: got id=%0d sum=%0h expected id=%0d sum=%0h",
                             res_id_s, res_sum_s, e.id, e.sum);
                end else begin
                    $display("signed result id=%0d sum=%0h ok", res_id_s, res_sum_s);
                end
            end
        end
    end

    initial begin
        exp_t e;
        int   i;
        int   k;
        logic [3:0] onehot;

        rst_n       = 1'b0;
        req_valid   = 4'hF;
        req_a       = '0;
        req_b       = '0;
        req_c       = '0;
        res_ready   = 1'b1;
        req_valid_s = 4'h0;
        req_a_s     = '0;
        req_b_s     = '0;
        req_c_s     = '0;
        res_ready_s = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_res_valid", 32'(res_valid), 32'h0);
        chk("reset_res_sum", 32'(res_sum), 32'h0);
        chk("reset_res_id", 32'(res_id), 32'h0);
        chk("reset_req_ready", 32'(req_ready), 32'h0);
        chk("reset_res_valid_s", 32'(res_valid_s), 32'h0);
        req_valid = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Unsigned max operands on req0, and signed -128-128-1 = -257 on req2
        push0(2'd0, 10'h2FD);
        set_req(0, 8'hFF, 8'hFF, 8'hFF);
        req_valid = 4'b0001;
        e.id = 2'd2;
        e.sum = 10'h2FF;
        q1.push_back(e);
        req_a_s[16 +: 8] = 8'h80;
        req_b_s[16 +: 8] = 8'h80;
        req_c_s[16 +: 8] = 8'hFF;
        req_valid_s = 4'b0100;
        @(negedge clk);
        chk("max_req_ready", 32'(req_ready), 32'h1);
        chk("signed_req_ready", 32'(req_ready_s), 32'h4);
        @(posedge clk);
        #1;
        req_valid   = 4'h0;
        req_valid_s = 4'h0;
        @(negedge clk);
        chk("max_latency_valid", 32'(res_valid), 32'h1);
        chk("signed_latency_valid", 32'(res_valid_s), 32'h1);
        @(posedge clk);
        #1;

        // rr_ptr=1: req3 alone, then req1+req3 with the pointer wrapped to 0
        push0(2'd3, 10'd6);
        set_req(3, 8'd1, 8'd2, 8'd3);
        req_valid = 4'b1000;
        @(negedge clk);
        chk("wrap_grant3", 32'(req_ready), 32'h8);
        @(posedge clk);
        #1;
        push0(2'd1, 10'd60);
        push0(2'd3, 10'd15);
        set_req(1, 8'd10, 8'd20, 8'd30);
        set_req(3, 8'd4, 8'd5, 8'd6);
        req_valid = 4'b1010;
        @(negedge clk);
        chk("wrap_grant1", 32'(req_ready), 32'h2);
        @(posedge clk);
        #1;
        req_valid = 4'b1000;
        @(negedge clk);
        chk("wrap_grant3_again", 32'(req_ready), 32'h8);
        @(posedge clk);
        #1;
        req_valid = 4'h0;
        @(posedge clk);
        #1;

        // Backpressure: hold FULL for 3 cycles, then drain and accept together
        res_ready = 1'b0;
        push0(2'd0, 10'h060);
        set_req(0, 8'h10, 8'h20, 8'h30);
        req_valid = 4'b0001;
        @(negedge clk);
        chk("hold_first_ready", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        push0(2'd1, 10'd3);
        set_req(1, 8'd1, 8'd1, 8'd1);
        req_valid = 4'b0010;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("hold_valid", 32'(res_valid), 32'h1);
            chk("hold_sum", 32'(res_sum), 32'h060);
            chk("hold_id", 32'(res_id), 32'h0);
            chk("hold_req_ready", 32'(req_ready), 32'h0);
            @(posedge clk);
            #1;
        end
        res_ready = 1'b1;
        @(negedge clk);
        chk("drain_accept_ready", 32'(req_ready), 32'h2);
        @(posedge clk);
        #1;
        req_valid = 4'h0;
        @(negedge clk);
        chk("drain_next_valid", 32'(res_valid), 32'h1);
        @(posedge clk);
        #1;

        // Reset while FULL: the in-flight result (req2) is discarded
        res_ready = 1'b0;
        set_req(2, 8'd7, 8'd7, 8'd7);
        req_valid = 4'b0100;
        @(negedge clk);
        chk("pre_reset_ready", 32'(req_ready), 32'h4);
        @(posedge clk);
        #1;
        for (int r = 0; r < 4; r++) begin
            set_req(r, 8'(r * 40), 8'd0, 8'hF0);
        end
        req_valid = 4'hF;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_res_valid", 32'(res_valid), 32'h0);
        chk("midreset_req_ready", 32'(req_ready), 32'h0);
        chk("midreset_res_sum", 32'(res_sum), 32'h0);
        res_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // All four valid: grants 0,1,2,3,0,1,2,3 back to back (rr_ptr restarted at 0)
        for (int n = 0; n < 8; n++) begin
            i = n % 4;
            k = n / 4;
            push0(2'(i), 10'(i * 40 + k) + 10'(k * 3) + 10'hF0);
        end
        for (int n = 0; n < 8; n++) begin
            i = n % 4;
            k = n / 4;
            onehot = 4'b0001 << i;
            chk("stream_grant", 32'(req_ready), 32'(onehot));
            @(posedge clk);
            #1;
            set_req(i, 8'(i * 40 + k + 1), 8'((k + 1) * 3), 8'hF0);
            if (n == 7) begin
                req_valid = 4'h0;
            end
            @(negedge clk);
            chk("stream_no_bubble", 32'(res_valid), 32'h1);
            #1;
        end

        repeat (3) @(negedge clk);
        chk("q0_drained", 32'(q0.size()), 32'h0);
        chk("q1_drained", 32'(q1.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
